// File: rtl/decoder16_skid.sv
// decoder16_skid: registered 4-to-16 one-hot decoder with valid/ready on both
// sides and a two-entry skid buffer (main register drives the outputs, skid
// register absorbs one entry while the consumer stalls).
// Optional feature: define DECODER16_SELFCHECK_EN to re-encode every departing
// entry and raise a sticky err on any inconsistent select/index pair.
module decoder16_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_en,
    input  logic [3:0]  in_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out,
    output logic [3:0]  out_idx,
    output logic        err
);

    logic        main_valid;
    logic [15:0] main_out;
    logic [3:0]  main_idx;
    logic        skid_valid;
    logic [15:0] skid_out;
    logic [3:0]  skid_idx;

    logic        in_fire;
    logic        out_fire;
    logic [15:0] dec_out;
    logic [3:0]  dec_idx;

    // Decode the incoming request; a disabled request carries an all-zero entry
    always_comb begin
        dec_out  = '0;
        dec_idx  = '0;
        in_fire  = in_valid && !skid_valid;
        out_fire = main_valid && out_ready;
        if (in_en) begin
            dec_out = 16'h0001 << in_idx;
            dec_idx = in_idx;
        end
    end

    // Main/skid storage; the skid is only ever filled while main is full and stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_out   <= '0;
            main_idx   <= '0;
            skid_valid <= 1'b0;
            skid_out   <= '0;
            skid_idx   <= '0;
        end else if (!main_valid) begin
            if (in_fire) begin
                main_valid <= 1'b1;
                main_out   <= dec_out;
                main_idx   <= dec_idx;
            end
        end else if (out_fire) begin
            if (skid_valid) begin
                main_out   <= skid_out;
                main_idx   <= skid_idx;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                main_out   <= dec_out;
                main_idx   <= dec_idx;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_out   <= dec_out;
            skid_idx   <= dec_idx;
        end
    end

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out       = main_out;
    assign out_idx   = main_idx;

`ifdef DECODER16_SELFCHECK_EN
    logic chk_ok;
    logic err_q;

    // Legal entries: exactly the bit at main_idx, or an all-zero select with index 0
    always_comb begin
        chk_ok = (main_out == (16'h0001 << main_idx)) ||
                 ((main_out == 16'h0000) && (main_idx == 4'd0));
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (out_fire && !chk_ok) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/decoder16_skid.md
# decoder16_skid

Registered 4-to-16 one-hot decoder with a valid/ready handshake on both sides and a two-entry skid buffer. It converts a 4-bit index into a 16-bit one-hot select, the inverse of the encoder16 mapping. Typical consumers are TLB/cache-way write-strobe generation and per-entry select lines. It sits between an index-producing pipeline stage and a consumer that may stall, sustaining one decode per cycle without a combinational ready path.

## Interface
Parameters:
- none; width fixed at 4-bit index / 16-bit one-hot.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream request valid
- in_ready  out  1  block can accept; registered, no combinational dependence on out_ready
- in_en  in  1  1 = decode in_idx; 0 = produce all-zero select
- in_idx  in  4  index to decode
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out  out  16  one-hot select (or zero)
- out_idx  out  4  index carried with the entry (0 when en was 0)
- err  out  1  sticky self-check error; tied 0 unless DECODER16_SELFCHECK_EN

## Operation
- Input fire: in_valid && in_ready. Output fire: out_valid && out_ready.
- Decode rule:
  - in_en=1: out = 16'b1 << in_idx, out_idx = in_idx.
  - in_en=0: out = 16'h0000, out_idx = 0.
- Storage: main register (drives outputs) plus one skid register. Entries leave in acceptance order; nothing is dropped or duplicated.
- Per-cycle update:
  - Main empty, input fire: entry loads into main.
  - Main full, output fire, skid empty, input fire: new entry loads into main.
  - Main full, no output fire, input fire: entry loads into skid.
  - Output fire with skid full: skid moves to main, skid empties. in_ready is 0 in this state, so there is no input fire.
  - Output fire, skid empty, no input fire: main empties.
- in_ready = ~skid_valid, registered.
- Outputs hold stable while out_valid && !out_ready.
- Reset, including mid-operation: both entries discarded. out_valid=0, out=16'h0000, out_idx=0, in_ready=1, err=0.

## Timing
- Latency: entry accepted at edge N appears with out_valid=1 after edge N.
- Throughput: one entry per cycle while out_ready=1.
- Stall absorption: one extra entry is accepted after out_ready drops. in_ready falls the cycle after the skid fills. in_ready rises the cycle after the skid drains.
- No combinational path from any input to any output.

## Configuration
- Macro DECODER16_SELFCHECK_EN.
- Defined: on every output fire, out is re-encoded and checked. A failure sets err, which stays 1 until rst.
  - A failure is anything other than: exactly one bit set at position out_idx, or out=0 with out_idx=0.
- Undefined: check logic omitted, err tied 0.
- Decode, handshake and timing are identical either way.

## Test plan
- Reset check: assert rst mid-stream with both entries full -> out_valid=0, out=0, out_idx=0, in_ready=1, err=0 immediately; no stale entry appears after release.
- Full decode sweep: out_ready=1, stream in_idx 0..15 with in_en=1 -> out = 0x0001, 0x0002 … 0x8000 on consecutive cycles, each one cycle after acceptance, out_idx matching.
- Disabled entry: in_en=0 with in_idx=9 -> out=0x0000, out_idx=0.
- Stall and skid: stream idx 3,4,5 and drop out_ready after idx 3 is presented.
  - Required: out holds 0x0008; idx 4 goes to skid; in_ready drops the next cycle; idx 5 waits upstream.
  - On release: 0x0010 then 0x0020, in order.
- Random backpressure: random in_valid/out_ready over 10k cycles -> scoreboard order and values match; in_ready never depends same-cycle on out_ready.
- Self-check (with DECODER16_SELFCHECK_EN): normal traffic -> err stays 0. Force a corrupt main register value 0x0011 -> err=1 after that output fire and remains 1 until rst.
